// File: rtl/par_lane_fifo_if.sv
// Handshake and data bundle for par_lane_fifo.
// The slave modport is the FIFO; the master modport is the producer/consumer side.
// Sticky error ports exist only when PAR_FIFO_ERR_EN is defined.
interface par_lane_fifo_if #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 4,
  parameter int PAR_WRITE = 1,
  parameter int PAR_READ  = 2
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic                        wr_valid;
  logic [PAR_WRITE*DATA_W-1:0] wr_data;
  logic                        wr_ready;
  logic                        rd_ready;
  logic                        rd_valid;
  logic [PAR_READ*DATA_W-1:0]  rd_data;
  logic [CW-1:0]               count;
  logic                        almost_full;
`ifdef PAR_FIFO_ERR_EN
  logic                        err_ovf;
  logic                        err_udf;
`endif

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count, almost_full
`ifdef PAR_FIFO_ERR_EN
    , output err_ovf, err_udf
`endif
  );

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count, almost_full
`ifdef PAR_FIFO_ERR_EN
    , input err_ovf, err_udf
`endif
  );
endinterface

// File: rtl/par_lane_fifo.sv
// par_lane_fifo: multi-lane FIFO, PAR_WRITE words in / PAR_READ words out per
// handshake, arbitrary DEPTH with explicit occupancy counter.
// Optional sticky overflow/underflow flags: define PAR_FIFO_ERR_EN.
module par_lane_fifo #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 4,
  parameter int PAR_WRITE = 1,
  parameter int PAR_READ  = 2,
  parameter int AFULL_TH  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  par_lane_fifo_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     waddr [PAR_WRITE];
  logic [AW-1:0]     raddr [PAR_READ];
  logic              wr_ready_w, rd_valid_w;
  logic              wf, rf;

  // base < DEPTH and off <= DEPTH, so one conditional subtract is a full modulo
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return AW'(sum);
  endfunction

  // Flags come from the registered count only; no same-cycle bypass
  assign wr_ready_w      = (DEPTH - int'(count_q)) >= PAR_WRITE;
  assign rd_valid_w      = int'(count_q) >= PAR_READ;
  assign wf              = bus.wr_valid && wr_ready_w;
  assign rf              = bus.rd_ready && rd_valid_w;
  assign bus.wr_ready    = wr_ready_w;
  assign bus.rd_valid    = rd_valid_w;
  assign bus.count       = count_q;
  assign bus.almost_full = int'(count_q) >= AFULL_TH;

  // Per-lane write addresses, wrapped individually
  for (genvar gi = 0; gi < PAR_WRITE; gi++) begin : g_wlane
    assign waddr[gi] = wrap_add(wptr_q, gi);
  end

  // Per-lane read addresses; read data is combinational from storage
  for (genvar gi = 0; gi < PAR_READ; gi++) begin : g_rlane
    assign raddr[gi] = wrap_add(rptr_q, gi);
    assign bus.rd_data[gi*DATA_W +: DATA_W] = mem_q[raddr[gi]];
  end

  // Next pointers and occupancy; clr discards any fire in the same cycle
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wf) wptr_d = wrap_add(wptr_q, PAR_WRITE);
      if (rf) rptr_d = wrap_add(rptr_q, PAR_READ);
      count_d = CW'(int'(count_q) + (wf ? PAR_WRITE : 0) - (rf ? PAR_READ : 0));
    end
  end

  // Pointer/occupancy registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents are intentionally not cleared by rst or clr
  always_ff @(posedge clk) begin
    if (wf && !clr) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        mem_q[waddr[i]] <= bus.wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef PAR_FIFO_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  // Sticky flags for requests the FIFO refused
  always_comb begin
    err_ovf_d = err_ovf_q | (bus.wr_valid & ~wr_ready_w);
    err_udf_d = err_udf_q | (bus.rd_ready & ~rd_valid_w);
    if (clr) begin
      err_ovf_d = 1'b0;
      err_udf_d = 1'b0;
    end
  end

  // Error flag registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign bus.err_ovf = err_ovf_q;
  assign bus.err_udf = err_udf_q;
`endif
endmodule

// File: doc/par_lane_fifo.md
# par_lane_fifo

Parametrised multi-lane FIFO that accepts `PAR_WRITE` words per write transaction and delivers `PAR_READ` words per read transaction. Both ports use valid/ready handshakes. Pointers wrap modulo an arbitrary `DEPTH` (not restricted to powers of two). Occupancy is tracked with an explicit counter rather than a spare slot. This block replaces the separate pointer-counter, comparator and difference-calculator datapath: storage, pointers, flags and occupancy live in one unit between the producer and consumer stages of the buffer subsystem.

## Interface
- `DATA_W`, 4, bits per word
- `DEPTH`, 4, storage words; must satisfy `DEPTH >= max(PAR_WRITE, PAR_READ)`
- `PAR_WRITE`, 1, words written per accepted write
- `PAR_READ`, 2, words read per accepted read
- `AFULL_TH`, 3, `almost_full` asserts when `count >= AFULL_TH`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `clr`  in  1  synchronous clear; same effect as reset at the next edge
- `wr_valid`  in  1  producer offers `PAR_WRITE` words
- `wr_data`  in  `PAR_WRITE*DATA_W`  lane 0 = `[DATA_W-1:0]` = oldest word
- `wr_ready`  out  1  FIFO can take `PAR_WRITE` words
- `rd_ready`  in  1  consumer takes `PAR_READ` words
- `rd_valid`  out  1  at least `PAR_READ` words stored
- `rd_data`  out  `PAR_READ*DATA_W`  lane 0 = oldest word
- `count`  out  `$clog2(DEPTH+1)`  stored words
- `almost_full`  out  1  `count >= AFULL_TH`
- `err_ovf`, `err_udf`  out  1 each  sticky error flags; present only with `PAR_FIFO_ERR_EN`

## Operation
- Write fire (`wf`) = `wr_valid && wr_ready`. On a write fire, lane i is stored at address `(wptr+i) mod DEPTH`, and `wptr` advances to `(wptr+PAR_WRITE) mod DEPTH`.
- Read fire (`rf`) = `rd_valid && rd_ready`. On a read fire, `rptr` advances to `(rptr+PAR_READ) mod DEPTH`.
- `rd_data` lane i = `mem[(rptr+i) mod DEPTH]`. It is combinational from registers, so there is no read latency.
- `count_next = count + PAR_WRITE*wf - PAR_READ*rf`, computed at a width that cannot wrap.
- `wr_ready = (DEPTH - count) >= PAR_WRITE`.
- `rd_valid = count >= PAR_READ`.
- Both flags are decoded from the registered `count` only. They never depend on the same-cycle opposite handshake, so there is no bypass and no pass-through.
- Simultaneous write and read fire: both commit in the same cycle. Writes go only to free slots, so they never overwrite the words being read.
- Wrap-around: the modulo is applied per lane address and per pointer update. With `DEPTH=5`, `wptr=4`, `PAR_WRITE=2`, the words go to addresses 4 and 0, and `wptr` becomes 1.
- Deasserting `wr_valid` while `wr_ready` is high, or `rd_ready` while `rd_valid` is high, is legal; no state changes.
- Priority: `rst` > `clr` > handshakes. With `clr` high, fires in that cycle are discarded.
- Storage is not cleared by `rst` or `clr`. `rd_data` is don't-care while `rd_valid` is 0.

## Timing
- Reset and `clr` values: `wptr=0`, `rptr=0`, `count=0`, `rd_valid=0`, `wr_ready=1`, `almost_full=0` (if `AFULL_TH>0`), `err_ovf=0`, `err_udf=0`.
- An asynchronous `rst` mid-transfer drops all stored data immediately. No output glitches to a non-reset value while `rst` is high.
- A write accepted at edge N:
  - raises `count` after edge N;
  - `rd_valid` may rise in the cycle after edge N;
  - the data is visible on `rd_data` in the same cycle.
- A read accepted at edge N frees its slots after edge N. `wr_ready` may rise in the cycle after edge N.
- Full throughput: when `PAR_WRITE == PAR_READ`, sustained one write plus one read per cycle is supported at any steady occupancy between `PAR_READ` and `DEPTH-PAR_WRITE`.

## Configuration
- `PAR_FIFO_ERR_EN` defined:
  - `err_ovf` sets at the edge where `wr_valid && !wr_ready`.
  - `err_udf` sets at the edge where `rd_ready && !rd_valid`.
  - Both flags are sticky until `rst` or `clr`.
  - The offending request is ignored; FIFO state is unchanged.
- `PAR_FIFO_ERR_EN` undefined: the ports and logic are absent, and such requests are silently ignored.

## Test plan
All scenarios use defaults unless stated.
- Reset: assert `rst` mid-cycle with `count=3` → `count=0`, `rd_valid=0`, `wr_ready=1`, `almost_full=0` without waiting for an edge.
- Fill: write 0xA, 0xB, 0xC, 0xD on 4 consecutive edges →
  - `count` steps 1, 2, 3, 4;
  - `rd_valid` high from the cycle after the 2nd write, with `rd_data={0xB,0xA}`;
  - `almost_full` high at `count=3`;
  - `wr_ready=0` at `count=4`.
- Drain: from the full state, hold `rd_ready` → `rd_data` shows `{0xB,0xA}`, then `{0xD,0xC}`; `count` goes 2, 0; `rd_valid` drops.
- Simultaneous: at `count=2` holding {0x1,0x2}, write 0x3 together with a read → `count=1`; the next `rd_valid` appears only after another write (0x4), giving `rd_data={0x4,0x3}`.
- Wrap: with `DEPTH=5`, `PAR_WRITE=2`, `PAR_READ=3`, run 20 random handshake cycles against a scoreboard → FIFO order is preserved across pointer wrap; `count` never exceeds 5.
- Errors and clear (with `PAR_FIFO_ERR_EN`):
  - write while `count=4` → `err_ovf=1`, `count` stays 4;
  - then pulse `clr` → all outputs return to reset values;
  - then read with `count=0` → `err_udf=1`.
